// File: rtl/alu_operand_pkg.sv
// alu_operand_pkg
//   Shared constants for the ALU operand stage: named source indices for the
//   default 4-source register/bus vector, the zero-source index, the operand
//   FSM state encoding and a helper mapping "which operands are held" to a
//   state.
package alu_operand_pkg;

  localparam int NSRC_DEF = 4;

  // Source indices into the packed src vector
  localparam int SRC_ACC  = 0;
  localparam int SRC_X    = 1;
  localparam int SRC_Y    = 2;
  localparam int SRC_DB   = 3;
  localparam int SRC_ZERO = NSRC_DEF;  // any sel >= NSRC decodes to zero

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_HAVE_A = 2'b01,
    ST_HAVE_B = 2'b10,
    ST_FULL   = 2'b11
  } op_state_t;

  // The state is fully described by which operands are held.
  function automatic op_state_t state_of(input logic have_a, input logic have_b);
    case ({have_b, have_a})
      2'b00:   state_of = ST_EMPTY;
      2'b01:   state_of = ST_HAVE_A;
      2'b10:   state_of = ST_HAVE_B;
      default: state_of = ST_FULL;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_stage_operand_mux.sv
// operand_mux
//   Combinational source selector. Returns source word `sel` from the packed
//   source vector; any sel >= NSRC returns zero.
// Ports:
//   src  [NSRC*WIDTH] packed sources, source k at [k*WIDTH +: WIDTH]
//   sel  [SELW]       source index
//   word [WIDTH]      selected word
module operand_mux #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 4,
  localparam int SELW = $clog2(NSRC+1)
) (
  input  logic [NSRC*WIDTH-1:0] src,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      word
);

  always_comb begin
    word = '0;
    for (int k = 0; k < NSRC; k++)
      if (sel == SELW'(k)) word = src[k*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Operand capture stage in front of the ALU. A and B are captured from the
//   source vector (same or different cycles); the complete pair is offered to
//   the ALU on a valid/ready handshake. The whole block freezes while rdy=0.
// Config macro:
//   ALU_OPERAND_BINV_EN - when defined, b_inv=1 captures ~source into B;
//                         otherwise b_inv is ignored.
// Ports:
//   clk, reset_l         clock, async active-low reset
//   rdy                  CPU ready (low = stall)
//   src                  packed sources
//   a_load/a_sel         capture A from source a_sel
//   b_load/b_sel/b_inv   capture B from source b_sel (optionally inverted)
//   a_op, b_op           operand registers
//   op_valid/op_ready    pair handshake to the ALU
//   overrun              sticky: a load was dropped while FULL
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NSRC  = 4,
  localparam int SELW = $clog2(NSRC+1)
) (
  input  logic                  clk,
  input  logic                  reset_l,
  input  logic                  rdy,
  input  logic [NSRC*WIDTH-1:0] src,
  input  logic                  a_load,
  input  logic [SELW-1:0]       a_sel,
  input  logic                  b_load,
  input  logic [SELW-1:0]       b_sel,
  input  logic                  b_inv,
  output logic [WIDTH-1:0]      a_op,
  output logic [WIDTH-1:0]      b_op,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic                  overrun
);

  // ---- source muxes: lane 0 = A, lane 1 = B ----
  logic [1:0][SELW-1:0]  sel_v;
  logic [1:0][WIDTH-1:0] word_v;
  logic [WIDTH-1:0]      b_word;

  assign sel_v = {b_sel, a_sel};

  for (genvar i = 0; i < 2; i++) begin : g_mux
    operand_mux #(.WIDTH(WIDTH), .NSRC(NSRC)) u_mux (
      .src  (src),
      .sel  (sel_v[i]),
      .word (word_v[i])
    );
  end

`ifdef ALU_OPERAND_BINV_EN
  assign b_word = b_inv ? ~word_v[1] : word_v[1];
`else
  logic unused_b_inv;
  assign unused_b_inv = b_inv;
  assign b_word       = word_v[1];
`endif

  // ---- FSM ----
  op_state_t state, nxt_state;
  logic      a_cap, b_cap, ovr_set;
  logic      held_a, held_b, accept;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= ST_EMPTY;
    else          state <= nxt_state;
  end

  // Loads are evaluated against what is still held after this edge's
  // consumption; a consumed FULL therefore behaves like EMPTY.
  always_comb begin
    nxt_state = state;
    a_cap     = 1'b0;
    b_cap     = 1'b0;
    ovr_set   = 1'b0;
    held_a    = 1'b0;
    held_b    = 1'b0;
    accept    = 1'b1;
    case (state)
      ST_HAVE_A: held_a = 1'b1;
      ST_HAVE_B: held_b = 1'b1;
      ST_FULL:   accept = op_ready;
      default:   ;
    endcase
    if (rdy) begin
      if (!accept) begin
        ovr_set = a_load | b_load;
      end else begin
        a_cap     = a_load;
        b_cap     = b_load;
        nxt_state = state_of(held_a | a_load, held_b | b_load);
      end
    end
  end

  // ---- operand registers ----
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      a_op    <= '0;
      b_op    <= '0;
      overrun <= 1'b0;
    end else begin
      if (a_cap)   a_op    <= word_v[0];
      if (b_cap)   b_op    <= b_word;
      if (ovr_set) overrun <= 1'b1;
    end
  end

  assign op_valid = (state == ST_FULL);

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model that tracks "A held / B held" flags and operand values.
module tb_alu_operand_stage;
  localparam int WIDTH = 8;
  localparam int NSRC  = 4;
  localparam int SELW  = $clog2(NSRC+1);

  logic                  clk = 1'b0;
  logic                  reset_l;
  logic                  rdy;
  logic [NSRC*WIDTH-1:0] src;
  logic                  a_load, b_load, b_inv, op_ready;
  logic [SELW-1:0]       a_sel, b_sel;
  logic [WIDTH-1:0]      a_op, b_op;
  logic                  op_valid, overrun;

  alu_operand_stage #(.WIDTH(WIDTH), .NSRC(NSRC)) dut (
    .clk(clk), .reset_l(reset_l), .rdy(rdy), .src(src),
    .a_load(a_load), .a_sel(a_sel), .b_load(b_load), .b_sel(b_sel),
    .b_inv(b_inv), .a_op(a_op), .b_op(b_op), .op_valid(op_valid),
    .op_ready(op_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // ---- reference model ----
  logic [WIDTH-1:0] m_a, m_b;
  bit               m_ha, m_hb, m_ovr;

  function automatic logic [WIDTH-1:0] ref_src(input logic [SELW-1:0] sel);
    int s = int'(sel);
    if (s < NSRC) return src[s*WIDTH +: WIDTH];
    return '0;
  endfunction

  task automatic model_reset();
    m_a = '0; m_b = '0; m_ha = 0; m_hb = 0; m_ovr = 0;
  endtask

  task automatic model_edge();
    logic [WIDTH-1:0] bv;
    if (!reset_l) begin model_reset(); return; end
    if (!rdy) return;
    if (m_ha && m_hb && !op_ready) begin
      if (a_load || b_load) m_ovr = 1;
      return;
    end
    if (m_ha && m_hb) begin m_ha = 0; m_hb = 0; end
    bv = ref_src(b_sel);
`ifdef ALU_OPERAND_BINV_EN
    if (b_inv) bv = ~bv;
`endif
    if (a_load) begin m_a = ref_src(a_sel); m_ha = 1; end
    if (b_load) begin m_b = bv;             m_hb = 1; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".a_op"},     32'(a_op),     32'(m_a));
    chk({tag, ".b_op"},     32'(b_op),     32'(m_b));
    chk({tag, ".op_valid"}, 32'(op_valid), 32'(m_ha && m_hb));
    chk({tag, ".overrun"},  32'(overrun),  32'(m_ovr));
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk); #1;
    chk_all(tag);
  endtask

  task automatic set_src(input int k, input logic [WIDTH-1:0] v);
    src[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic idle();
    a_load = 0; b_load = 0; op_ready = 0; b_inv = 0; rdy = 1;
  endtask

  initial begin
    reset_l = 0; rdy = 1; src = '0; a_load = 1; b_load = 1;
    a_sel = SELW'(1); b_sel = SELW'(2); b_inv = 0; op_ready = 0;
    set_src(1, 8'h11); set_src(2, 8'h22);
    model_reset();
    // reset with loads pending
    cycle("rst0");
    cycle("rst1");
    chk("rst.op_valid", 32'(op_valid), 32'd0);
    #2 reset_l = 1; idle();
    @(negedge clk);

    // split load: A at edge 1, B at edge 3, consume at edge 4
    set_src(0, 8'h3C); set_src(1, 8'h05);
    a_load = 1; a_sel = SELW'(0);
    cycle("split1");
    a_load = 0;
    cycle("split2");
    chk("split.not_valid", 32'(op_valid), 32'd0);
    b_load = 1; b_sel = SELW'(1);
    cycle("split3");
    chk("split.valid", 32'(op_valid), 32'd1);
    b_load = 0; op_ready = 1;
    cycle("split4");
    chk("split.consumed", 32'(op_valid), 32'd0);
    chk("split.a_held",   32'(a_op),     32'h3C);

    // back-to-back with Y = 0x10..0x13
    a_load = 1; b_load = 1; a_sel = SELW'(0); b_sel = SELW'(2);
    for (int i = 0; i < 4; i++) begin
      set_src(2, WIDTH'(8'h10 + i));
      cycle("b2b");
      chk("b2b.b_op",  32'(b_op),     32'(8'h10 + i));
      chk("b2b.valid", 32'(op_valid), 32'd1);
    end

    // overrun: FULL, not ready, A load with DB=0xFF
    op_ready = 0; b_load = 0; a_sel = SELW'(3); set_src(3, 8'hFF);
    cycle("ovr1");
    chk("ovr.a_kept",  32'(a_op),    32'h3C);
    chk("ovr.sticky1", 32'(overrun), 32'd1);
    a_load = 0; op_ready = 1;
    cycle("ovr2");
    chk("ovr.sticky2", 32'(overrun), 32'd1);

    // stall: fill, then rdy=0 with ready and loads for 3 cycles
    op_ready = 0; a_load = 1; b_load = 1; a_sel = SELW'(1); b_sel = SELW'(1);
    cycle("stall.fill");
    rdy = 0; op_ready = 1; set_src(1, 8'h77);
    for (int i = 0; i < 3; i++) begin
      cycle("stall");
      chk("stall.a_op",  32'(a_op),     32'h05);
      chk("stall.valid", 32'(op_valid), 32'd1);
    end
    rdy = 1; a_load = 0; b_load = 0;
    cycle("stall.release");
    chk("stall.xfer", 32'(op_valid), 32'd0);

    // invert / zero source
    set_src(3, 8'h5A); b_load = 1; b_sel = SELW'(3); b_inv = 1;
    a_load = 1; a_sel = SELW'(NSRC); op_ready = 0;
    cycle("inv");
`ifdef ALU_OPERAND_BINV_EN
    chk("inv.b_op", 32'(b_op), 32'hA5);
`else
    chk("inv.b_op", 32'(b_op), 32'h5A);
`endif
    chk("zero.a_op", 32'(a_op), 32'h00);

    // async reset while FULL
    idle();
    chk("areset.pre_valid", 32'(op_valid), 32'd1);
    #2 reset_l = 0; #1;
    model_reset();
    chk_all("areset");
    @(posedge clk); #1 reset_l = 1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      src      = {$urandom, $urandom};
      rdy      = ($urandom_range(0, 7) != 0);
      a_load   = $urandom_range(0, 1) == 1;
      b_load   = $urandom_range(0, 1) == 1;
      a_sel    = SELW'($urandom_range(0, NSRC));
      b_sel    = SELW'($urandom_range(0, NSRC));
      b_inv    = $urandom_range(0, 1) == 1;
      op_ready = $urandom_range(0, 3) != 0;
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

- Parametrised operand stage in front of the CPU ALU.
- Captures the A and B operands from an N-source register/bus vector. The two operands may be captured in the same cycle or in different cycles.
- Presents the complete operand pair to the ALU through a valid/ready handshake.
- Supports an optional B-operand inversion (used for subtract/compare).
- Sits between the register file (ACC, X, Y, data bus, …) and the ALU datapath.
- Honours the CPU-wide `rdy` stall.

## Interface
- `WIDTH`, 8, operand width in bits
- `NSRC`, 4, number of selectable sources; source index `NSRC` is the constant zero; select width `SELW` = $clog2(NSRC+1)
- `clk` input 1: sole clock, rising edge
- `reset_l` input 1: reset, asynchronous, active-low
- `rdy` input 1: CPU ready; low freezes the whole block
- `src` input NSRC*WIDTH: packed sources; source k occupies bits [k*WIDTH +: WIDTH]
- `a_load` input 1: capture A operand this cycle
- `a_sel` input SELW: A source index
- `b_load` input 1: capture B operand this cycle
- `b_sel` input SELW: B source index
- `b_inv` input 1: invert B as it is captured
- `a_op` output WIDTH: A operand register
- `b_op` output WIDTH: B operand register
- `op_valid` output 1: both operands captured and not yet consumed
- `op_ready` input 1: ALU accepts the pair
- `overrun` output 1: sticky; a load was dropped while the stage was FULL

## Operation
- Reset values: `a_op`=0, `b_op`=0, `op_valid`=0, `overrun`=0; state=EMPTY.
- Select decode: sel < NSRC → that source; sel ≥ NSRC → zero.
- FSM states: EMPTY, HAVE_A, HAVE_B, FULL; `op_valid` = (state==FULL), registered.
- Transitions with `rdy`=1:
  - EMPTY: a&b→FULL; a→HAVE_A; b→HAVE_B.
  - HAVE_A: b→FULL.
  - HAVE_B: a→FULL.
  - A load of an operand already held in HAVE_A/HAVE_B overwrites that operand; state is unchanged.
  - FULL with `op_ready`: the pair is consumed. Loads in the same cycle are evaluated as from EMPTY, so a&b keeps FULL with the new pair.
  - FULL without `op_ready`: loads are dropped, registers hold, `overrun` sets.
- Consumption does not clear `a_op`/`b_op`; they hold their last value.
- `overrun` clears only on reset.
- `rdy`=0: no capture, no state change, `op_ready` ignored, `overrun` not set.
- Reset asserted mid-operation forces reset values immediately (asynchronously); an in-flight pair is discarded.

## Timing
- Capture latency: 1 cycle. A load at edge N updates `a_op`/`b_op` after edge N.
- `op_valid` rises after the edge that completes the pair. Both operands loaded on the same edge → `op_valid` rises after that edge.
- Handshake: the transfer occurs on an edge where `op_valid`&`op_ready`&`rdy` are all 1.
- `op_valid` falls after that edge unless a new pair is loaded on the same edge.
- `op_ready` may be asserted while `op_valid` is low; it has no effect then.
- Throughput: one pair per cycle when both operands are loaded every cycle alongside `op_ready`.

## Configuration
- `ALU_OPERAND_BINV_EN` defined: B captures ~source when `b_inv`=1, else source.
- `ALU_OPERAND_BINV_EN` undefined: `b_inv` is ignored and B always captures the source unmodified. The port is retained so instantiation does not change.

## Structure
- Shared constants package/include holds:
  - source indices: `SRC_ACC`=0, `SRC_X`=1, `SRC_Y`=2, `SRC_DB`=3
  - `SRC_ZERO`=NSRC
  - FSM state encodings
- One sub-module: `operand_mux`, parametrised by WIDTH/NSRC. Purely combinational: sel → word, with the zero source. It is instantiated twice, for A and B.
- The FSM and registers live in the top module.

## Test plan
- Reset: drive loads during `reset_l`=0 → `a_op`=0, `b_op`=0, `op_valid`=0, `overrun`=0. Assert `reset_l` while FULL → all cleared asynchronously.
- Split load: ACC=0x3C, A from `SRC_ACC` at edge 1, X=0x05, B from `SRC_X` at edge 3 → `op_valid` high only after edge 3. With `op_ready`=1 at edge 4 → `op_valid` low and `a_op`=0x3C held.
- Back-to-back: a&b loaded every cycle with `op_ready`=1, Y=0x10..0x13 → `op_valid` stays 1 and B tracks 0x10..0x13 with 1-cycle latency.
- Overrun: FULL, `op_ready`=0, `a_load` with DB=0xFF → `a_op` unchanged and `overrun`=1, sticky through a later consume.
- Stall: `rdy`=0 with `op_ready`=1 and loads pending for 3 cycles → no state or register change. `rdy`=1 → the transfer completes.
- Invert/zero (macro defined): DB=0x5A, `b_inv`=1 → `b_op`=0xA5. `a_sel`=NSRC → `a_op`=0x00. Macro undefined → `b_op`=0x5A.
